// File: rtl/riscv_defs_pkg.sv
// Shared RV32 definitions for the fetch path:
// opcodes, NOP word, fetch FSM states and buffer entry layout.
package riscv_defs_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push and pop in the same cycle.
module fetch_buffer
  import riscv_defs_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = bump(wr_q);
      if (pop_i)  rd_d = bump(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, buffered output
// to decode, redirect flush with drain of an in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic [6:0]  if_opcode
);

  import riscv_defs_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;
  logic          push, pop, flush, room;
  logic          unused_pc_lsb;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .count_o (count)
  );

  assign unused_pc_lsb  = ^redirect_pc[1:0];
  assign room           = count < CW'(BUF_DEPTH);
  assign imem_addr      = pc_q;
  assign if_valid       = count != '0;
  assign if_pc          = if_valid ? head.pc : '0;
  assign if_instruction = if_valid ? head.instr : NOP_INSTR;
  assign if_opcode      = if_instruction[6:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    pop      = if_valid && !stall;
    flush    = redirect;
    // pc already advanced on acceptance, so the request was pc-4
    push_data.pc    = pc_q - 32'd4;
    push_data.instr = imem_rdata;
    unique case (state_q)
      ST_FETCH: begin
        imem_req = room && !redirect && !reset;
        if (imem_req && imem_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect;
          state_d = ST_FETCH;
        end else if (redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (redirect) pc_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a
// queue-level reference model of the fetch/decode contract.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instruction;
  logic [6:0]  if_opcode;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_pc, d2_instr;
  logic [6:0]  d2_opc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_instruction(if_instruction), .if_opcode(if_opcode)
  );

  // same stimulus, reset vector just below the wrap point
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) dut_hi (
    .clk(clk), .reset(reset),
    .imem_req(d2_req), .imem_addr(d2_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(d2_valid), .if_pc(d2_pc),
    .if_instruction(d2_instr), .if_opcode(d2_opc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc, m_rpc;
  bit          m_pend, m_drop, m_clean;
  bit          mem_busy;
  int          mem_cnt, next_lat;
  logic [31:0] mem_data, next_data;
  int          n_cmp, n_err, n_acc;
  logic [31:0] last_addr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    stall       = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_ifpc", if_pc, 0);
    check("rst_instr", if_instruction, NOP);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_pc     = 32'h0;
    m_pend   = 1'b0;
    m_drop   = 1'b0;
    m_clean  = 1'b1;
    mem_busy = 1'b0;
  endtask

  task automatic cycle(input bit s, input bit r,
                       input logic [31:0] rpc, input bit rdy);
    bit          er, ev, acc, do_push;
    logic [31:0] epc, eins;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
      end
    end
    @(negedge clk);
    er   = !m_pend && (m_q.size() < DEPTH) && !r;
    ev   = m_q.size() != 0;
    epc  = 32'h0;
    eins = NOP;
    if (ev) begin
      epc  = m_q[0].pc;
      eins = m_q[0].ins;
    end
    check("req", imem_req, er);
    if (er) check("addr", imem_addr, m_pc);
    check("valid", if_valid, ev);
    check("ifpc", if_pc, epc);
    check("instr", if_instruction, eins);
    check("opcode", if_opcode, eins[6:0]);
    if (m_clean) begin
      check("hi_req", d2_req, er);
      if (er) check("hi_addr", d2_addr, m_pc - 32'd4);
    end
    if (imem_req && imem_ready) begin
      n_acc++;
      last_addr = imem_addr;
    end
    acc     = er && rdy;
    do_push = imem_rvalid && !m_drop;
    if (imem_rvalid) begin
      m_pend = 1'b0;
      m_drop = 1'b0;
    end
    if (r) begin
      m_q.delete();
      m_pc    = {rpc[31:2], 2'b00};
      m_clean = 1'b0;
      if (m_pend) m_drop = 1'b1;
    end else begin
      if (ev && !s) m_q.delete(0);
      if (do_push) m_q.push_back('{pc: m_rpc, ins: imem_rdata});
      if (acc) begin
        m_rpc  = m_pc;
        m_pc   = m_pc + 32'd4;
        m_pend = 1'b1;
      end
    end
    if (imem_rvalid) mem_busy = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = next_lat;
      mem_data = next_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t limit %0d", $time, 1000000);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_acc = 0;
    #2;
    do_reset();

    // first fetch returns addi x1,x0,5
    next_lat  = 1;
    next_data = 32'h0050_0093;
    cycle(0, 0, 32'h0, 1);
    check("r35_addr", last_addr, 32'h0);
    cycle(0, 0, 32'h0, 1);
    check("r35_valid", if_valid, 1);
    check("r35_ifpc", if_pc, 32'h0);
    check("r35_opc", if_opcode, 7'b0010011);
    repeat (3) cycle(0, 0, 32'h0, 1);

    // decode stalled from reset: buffer fills, fetch stops
    do_reset();
    n_acc = 0;
    repeat (10) begin
      next_data = $urandom;
      cycle(1, 0, 32'h0, 1);
    end
    check("r36_nreq", n_acc, 2);
    check("r36_req_off", imem_req, 0);
    check("r36_ifpc", if_pc, 32'h0);
    repeat (4) cycle(0, 0, 32'h0, 1);

    // redirect while waiting: stale response dropped
    do_reset();
    next_lat  = 3;
    next_data = $urandom;
    cycle(0, 0, 32'h0, 1);
    cycle(0, 1, 32'h0000_0103, 1);
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc == 0; i++) cycle(0, 0, 32'h0, 1);
    check("r37_nacc", n_acc, 1);
    check("r37_addr", last_addr, 32'h0000_0100);

    // redirect together with rvalid and a buffered entry
    do_reset();
    next_lat = 1;
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 1, 32'h0000_0200, 1);
    check("r38_valid", if_valid, 0);
    n_acc = 0;
    cycle(0, 0, 32'h0, 1);
    check("r38_addr", last_addr, 32'h0000_0200);

    // pc wrap through redirect to the top word
    do_reset();
    next_lat = 1;
    cycle(0, 1, 32'hFFFF_FFFE, 1);
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 2; i++) cycle(0, 0, 32'h0, 1);
    check("wrap_nacc", n_acc, 2);
    check("wrap_addr", last_addr, 32'h0);

    // reset while a request is pending unaccepted
    do_reset();
    cycle(0, 0, 32'h0, 0);
    imem_ready = 1'b0;
    #1;
    check("r40_req_pre", imem_req, 1);
    do_reset();

    for (int i = 0; i < 4000; i++) begin
      next_lat  = int'($urandom_range(1, 3));
      next_data = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
